// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_txn_arbiter
//  Purpose  : Round-robin arbiter that shares one I2C master between NREQ
//             requesters. Each accepted transaction (7-bit address, R/W bit,
//             data byte) is launched on the master with a one-cycle enable.
//             The arbiter then waits for the master's completion pulse or
//             for a timeout, and returns a one-cycle per-requester response.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   asynchronous active-high reset
//    req_valid  in   [NREQ]         request per requester, held until ready
//    req_addr   in   [NREQ*ADDR_W]  slot i at [i*ADDR_W +: ADDR_W]
//    req_rw     in   [NREQ]         1 = read, 0 = write
//    req_data   in   [NREQ*DATA_W]  slot i at [i*DATA_W +: DATA_W]
//    req_ready  out  [NREQ]         one-hot accept pulse (LAUNCH cycle)
//    rsp_valid  out  [NREQ]         one-hot completion pulse (RESP cycle)
//    rsp_err    out                 timeout flag, qualified by rsp_valid
//    mst_en     out                 one-cycle launch pulse to the master
//    mst_rw     out                 R/W bit to the master
//    mst_addr   out  [ADDR_W]       device address to the master
//    mst_data   out  [DATA_W]       data byte to the master
//    mst_done   in                  completion pulse from the master
//    busy       out                 high from LAUNCH through RESP
//    grant_idx  out  [clog2(NREQ)]  current or last granted requester
// ============================================================================
module i2c_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0]           req_rw,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_err,
    output logic                      mst_en,
    output logic                      mst_rw,
    output logic [ADDR_W-1:0]         mst_addr,
    output logic [DATA_W-1:0]         mst_data,
    input  logic                      mst_done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_idx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_idx_w = $clog2(NREQ);
    localparam int c_cnt_w = $clog2(TIMEOUT);

    // Last counter value before abort: WAIT exits here, so the counter
    // never wraps.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    // Pointer resets to the top slot so requester 0 wins the first search.
    localparam logic [c_idx_w-1:0] c_ptr_init = c_idx_w'(NREQ - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_launch = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [1:0]          r_state_q,     w_state_d;
    logic [c_idx_w-1:0]  r_ptr_q,       w_ptr_d;
    logic [c_cnt_w-1:0]  r_cnt_q,       w_cnt_d;
    logic [c_idx_w-1:0]  r_grant_q,     w_grant_d;
    logic                r_mst_rw_q,    w_mst_rw_d;
    logic [ADDR_W-1:0]   r_mst_addr_q,  w_mst_addr_d;
    logic [DATA_W-1:0]   r_mst_data_q,  w_mst_data_d;
    logic                r_mst_en_q,    w_mst_en_d;
    logic [NREQ-1:0]     r_req_ready_q, w_req_ready_d;
    logic [NREQ-1:0]     r_rsp_valid_q, w_rsp_valid_d;
    logic                r_rsp_err_q,   w_rsp_err_d;
    logic                r_busy_q,      w_busy_d;

    // ------------------------------------------------------------------------
    // Request slot unpacking
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_slot_addr [NREQ];
    logic [DATA_W-1:0] w_slot_data [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign w_slot_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_slot_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------------
    // Round-robin winner: first valid slot found searching upward from
    // last+1 with wrap-around. Only meaningful when any req_valid bit is set.
    // ------------------------------------------------------------------------
    function automatic logic [c_idx_w-1:0] f_rr_pick(
        input logic [NREQ-1:0]    valid,
        input logic [c_idx_w-1:0] last
    );
        logic [c_idx_w-1:0] pick;
        logic               found;
        int unsigned        slot;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            slot = 32'(last) + k;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            if (!found && valid[slot[c_idx_w-1:0]]) begin
                found = 1'b1;
                pick  = slot[c_idx_w-1:0];
            end
        end
        return pick;
    endfunction

    logic [c_idx_w-1:0] w_pick;
    logic               w_any_req;
    logic               w_timeout;

    assign w_pick    = f_rr_pick(req_valid, r_ptr_q);
    assign w_any_req = |req_valid;
    assign w_timeout = (r_cnt_q == c_cnt_last);

    // ------------------------------------------------------------------------
    // State register (all flops, including the registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q     <= c_st_idle;
            r_ptr_q       <= c_ptr_init;
            r_cnt_q       <= '0;
            r_grant_q     <= '0;
            r_mst_rw_q    <= 1'b0;
            r_mst_addr_q  <= '0;
            r_mst_data_q  <= '0;
            r_mst_en_q    <= 1'b0;
            r_req_ready_q <= '0;
            r_rsp_valid_q <= '0;
            r_rsp_err_q   <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_cnt_q       <= w_cnt_d;
            r_grant_q     <= w_grant_d;
            r_mst_rw_q    <= w_mst_rw_d;
            r_mst_addr_q  <= w_mst_addr_d;
            r_mst_data_q  <= w_mst_data_d;
            r_mst_en_q    <= w_mst_en_d;
            r_req_ready_q <= w_req_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_busy_q      <= w_busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: state, pointer, counter and captured payload
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_ptr_d      = r_ptr_q;
        w_cnt_d      = r_cnt_q;
        w_grant_d    = r_grant_q;
        w_mst_rw_d   = r_mst_rw_q;
        w_mst_addr_d = r_mst_addr_q;
        w_mst_data_d = r_mst_data_q;

        case (r_state_q)
            c_st_idle: begin
                if (w_any_req) begin
                    w_state_d    = c_st_launch;
                    w_grant_d    = w_pick;
                    w_mst_rw_d   = req_rw[w_pick];
                    w_mst_addr_d = w_slot_addr[w_pick];
                    w_mst_data_d = w_slot_data[w_pick];
                end
            end
            c_st_launch: begin
                w_state_d = c_st_wait;
                w_cnt_d   = '0;
            end
            c_st_wait: begin
                // Completion is checked first so a done arriving on the
                // final timeout cycle still counts as success.
                if (mst_done || w_timeout) begin
                    w_state_d = c_st_resp;
                end else begin
                    w_cnt_d = r_cnt_q + c_cnt_w'(1);
                end
            end
            c_st_resp: begin
                w_state_d = c_st_idle;
                w_ptr_d   = r_grant_q;
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs, derived from the
    // state being entered so each pulse lines up with its state cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mst_en_d    = 1'b0;
        w_req_ready_d = '0;
        w_rsp_valid_d = '0;
        w_rsp_err_d   = 1'b0;
        w_busy_d      = (w_state_d != c_st_idle);

        if (w_state_d == c_st_launch) begin
            w_mst_en_d    = 1'b1;
            w_req_ready_d = NREQ'(1) << w_pick;
        end

        // RESP is only reachable from WAIT; without done the exit was a
        // timeout.
        if (w_state_d == c_st_resp) begin
            w_rsp_valid_d = NREQ'(1) << r_grant_q;
            w_rsp_err_d   = ~mst_done;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign req_ready = r_req_ready_q;
    assign rsp_valid = r_rsp_valid_q;
    assign rsp_err   = r_rsp_err_q;
    assign mst_en    = r_mst_en_q;
    assign mst_rw    = r_mst_rw_q;
    assign mst_addr  = r_mst_addr_q;
    assign mst_data  = r_mst_data_q;
    assign busy      = r_busy_q;
    assign grant_idx = r_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_txn_arbiter
//  Purpose  : Self-checking bench for i2c_txn_arbiter: a table of directed
//             transactions, hand-written stray-done and mid-WAIT reset
//             sequences, and randomized transactions predicted by a
//             transaction-level round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ-1:0]         req_rw;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         rsp_valid;
    logic                    rsp_err;
    logic                    mst_en;
    logic                    mst_rw;
    logic [ADDR_W-1:0]       mst_addr;
    logic [DATA_W-1:0]       mst_data;
    logic                    mst_done;
    logic                    busy;
    logic [1:0]              grant_idx;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .mst_en    (mst_en),
        .mst_rw    (mst_rw),
        .mst_addr  (mst_addr),
        .mst_data  (mst_data),
        .mst_done  (mst_done),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr;   // model: last served requester

    logic [ADDR_W-1:0] p_addr [NREQ];
    logic              p_rw   [NREQ];
    logic [DATA_W-1:0] p_data [NREQ];

    typedef struct {
        logic [NREQ-1:0] mask;
        int              delay;   // WAIT cycle carrying mst_done; <=0 never
        int              exp_w;
        logic            exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round robin as a rotated search: first set bit after 'last', mod NREQ.
    function automatic int model_pick(input logic [NREQ-1:0] mask, input int last);
        int s;
        for (int k = 1; k <= NREQ; k++) begin
            s = (last + k) % NREQ;
            if (((mask >> s) & 4'b0001) != 4'b0000) return s;
        end
        return -1;
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = p_addr[i];
            req_rw[i]                    = p_rw[i];
            req_data[i*DATA_W +: DATA_W] = p_data[i];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle following RESP.
    task automatic run_txn(input string tag, input logic [NREQ-1:0] mask, input int delay,
                           input int exp_w, input logic exp_err, input bit noisy);
        int                resp_c;
        logic [ADDR_W-1:0] e_addr;
        logic              e_rw;
        logic [DATA_W-1:0] e_data;
        e_addr = p_addr[exp_w];
        e_rw   = p_rw[exp_w];
        e_data = p_data[exp_w];
        resp_c = (delay >= 1 && delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;

        drive_payload();
        req_valid = mask;
        mst_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk({tag, " launch en/busy/rsp"}, 32'({mst_en, busy, rsp_valid}), 32'({1'b1, 1'b1, 4'b0}));
        chk({tag, " req_ready"}, 32'(req_ready), 1 << exp_w);
        chk({tag, " grant_idx"}, 32'(grant_idx), exp_w);
        chk({tag, " mst payload"}, 32'({mst_addr, mst_rw, mst_data}), 32'({e_addr, e_rw, e_data}));
        req_valid = req_valid & ~(4'b0001 << exp_w);
        mst_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;

        for (int c = 1; c <= resp_c; c++) begin
            @(negedge clk);
            if (noisy) begin
                req_valid = 4'($urandom);
                req_addr  = 28'($urandom);
                req_rw    = 4'($urandom);
                req_data  = 32'($urandom);
            end
            if (c < resp_c) begin
                chk({tag, " wait outputs"}, 32'({mst_en, req_ready, rsp_valid, busy}),
                    32'({1'b0, 4'b0, 4'b0, 1'b1}));
                mst_done = (c == delay);
            end else begin
                chk({tag, " rsp_valid"}, 32'(rsp_valid), 1 << exp_w);
                chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
                chk({tag, " resp busy/en"}, 32'({busy, mst_en}), 32'({1'b1, 1'b0}));
                chk({tag, " resp held payload"}, 32'({mst_addr, mst_rw, mst_data, grant_idx}),
                    32'({e_addr, e_rw, e_data, 2'(exp_w)}));
                mst_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, " back idle"}, 32'({busy, rsp_valid, rsp_err, mst_en, req_ready}), 0);
        mst_done  = 1'b0;
        req_valid = '0;
        m_ptr     = exp_w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] mask;
        int              delay;
        int              w;

        vecs[0]  = '{4'hF,  3, 0, 1'b0};   // fairness 0,1,2,3,0
        vecs[1]  = '{4'hF,  3, 1, 1'b0};
        vecs[2]  = '{4'hF,  3, 2, 1'b0};
        vecs[3]  = '{4'hF,  3, 3, 1'b0};
        vecs[4]  = '{4'hF,  3, 0, 1'b0};
        vecs[5]  = '{4'h1, 12, 0, 1'b0};   // single write 50/0/A5
        vecs[6]  = '{4'h4,  2, 2, 1'b0};
        vecs[7]  = '{4'h5,  1, 0, 1'b0};   // pointer skip: 3 then 0
        vecs[8]  = '{4'h5,  1, 2, 1'b0};
        vecs[9]  = '{4'h2, -1, 1, 1'b1};   // read times out
        vecs[10] = '{4'h8, 16, 3, 1'b0};   // done on last timeout cycle
        vecs[11] = '{4'hA, 17, 1, 1'b1};   // done too late: timeout
        vecs[12] = '{4'hA,  5, 3, 1'b0};
        vecs[13] = '{4'h9,  1, 0, 1'b0};

        p_addr[0] = 7'h50; p_rw[0] = 1'b0; p_data[0] = 8'hA5;
        p_addr[1] = 7'h2C; p_rw[1] = 1'b1; p_data[1] = 8'h3C;
        p_addr[2] = 7'h11; p_rw[2] = 1'b0; p_data[2] = 8'h77;
        p_addr[3] = 7'h7F; p_rw[3] = 1'b1; p_data[3] = 8'h00;

        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_rw    = '0;
        req_data  = '0;
        mst_done  = 1'b0;
        @(negedge clk);
        chk("reset state", 32'({req_ready, rsp_valid, rsp_err, mst_en, mst_rw, busy, grant_idx}), 0);
        chk("reset payload", 32'({mst_addr, mst_data}), 0);
        reset = 1'b0;
        m_ptr = NREQ - 1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].delay,
                    vecs[i].exp_w, vecs[i].exp_err, 1'b0);
        end

        // Stray mst_done while idle
        mst_done = 1'b1;
        @(negedge clk);
        mst_done = 1'b0;
        chk("stray done idle", 32'({busy, mst_en, rsp_valid, req_ready}), 0);
        @(negedge clk);
        chk("stray done after", 32'({busy, mst_en, rsp_valid, req_ready}), 0);
        run_txn("after stray", 4'h4, 4, model_pick(4'h4, m_ptr), 1'b0, 1'b0);

        // Reset in the middle of WAIT
        drive_payload();
        req_valid = 4'h2;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset outputs", 32'({req_ready, rsp_valid, rsp_err, mst_en, mst_rw, busy, grant_idx}), 0);
        chk("async reset payload", 32'({mst_addr, mst_data}), 0);
        mst_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in reset no rsp", 32'({rsp_valid, busy}), 0);
        reset    = 1'b0;
        mst_done = 1'b0;
        m_ptr    = NREQ - 1;
        @(negedge clk);
        chk("post reset idle", 32'({rsp_valid, busy, mst_en}), 0);
        run_txn("post reset", 4'h3, 3, 0, 1'b0, 1'b0);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                p_addr[i] = 7'($urandom);
                p_rw[i]   = 1'($urandom);
                p_data[i] = 8'($urandom);
            end
            mask  = 4'($urandom_range(1, 15));
            delay = $urandom_range(1, TIMEOUT + 3);
            w     = model_pick(mask, m_ptr);
            run_txn($sformatf("rnd%0d", n), mask, delay, w, (delay > TIMEOUT), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
